uart_tx_arbiter: RTL

- Shares the single ip_uart transmitter (27 MHz, 115200 baud) between NUM_CH byte-stream clients, for example the boot banner, the MSX bus trace and the PSRAM debug.
- Grants round-robin at packet granularity. Once a client's byte is accepted, that client keeps the UART until it sends a byte flagged last, or until it stalls past a timeout.
- Sits in the top level between the clients and u_uart; drives send_data/send_req and observes send_busy.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit arbiter slice.
package uart_pkg;

   localparam int unsigned CLK_HZ_DEF       = 27_000_000;
   localparam int unsigned BAUD_DEF         = 115_200;
   localparam int unsigned BIT_CYCLES_DEF   = CLK_HZ_DEF / BAUD_DEF;
   localparam int unsigned LOCK_TIMEOUT_DEF = 270_000;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   // Client index width; never below one bit so two-client builds still index cleanly.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client byte streams, ip_uart handshake and grant status between arbiter and top level.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
);
   localparam int unsigned IDW = id_width(NUM_CH);

   logic [NUM_CH-1:0]   ch_req;
   logic [8*NUM_CH-1:0] ch_data;
   logic [NUM_CH-1:0]   ch_last;
   logic [NUM_CH-1:0]   ch_ack;
   logic [7:0]          send_data;
   logic                send_req;
   logic                send_busy;
   logic                grant_valid;
   logic [IDW-1:0]      grant_id;
   logic                locked;

   modport master (
      input  ch_req, ch_data, ch_last, send_busy,
      output ch_ack, send_data, send_req, grant_valid, grant_id, locked
   );

   modport slave (
      output ch_req, ch_data, ch_last, send_busy,
      input  ch_ack, send_data, send_req, grant_valid, grant_id, locked
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set request starting at ptr, wrapping modulo NUM_CH.
module rr_pick #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned IDW    = 2
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [IDW-1:0]    i_ptr,
   output logic [IDW-1:0]    o_sel,
   output logic              o_found
);

   always_comb begin
      logic [IDW-1:0] w_idx;
      o_sel   = '0;
      o_found = 1'b0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         w_idx = IDW'((32'(i_ptr) + k) % NUM_CH);
         if (!o_found && i_req[w_idx]) begin
            o_sel   = w_idx;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one ip_uart transmitter among NUM_CH clients.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
   input  logic              sys_clk,
   input  logic              w_n_reset,
   uart_tx_arbiter_if.master bus
);

   localparam int unsigned IDW = id_width(NUM_CH);
   localparam int unsigned TW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

   state_t            r_state;
   logic [NUM_CH-1:0] r_ack;
   logic [7:0]        r_send_data;
   logic              r_send_req;
   logic              r_grant_valid;
   logic [IDW-1:0]    r_grant_id;
   logic              r_locked;
   logic [IDW-1:0]    r_rr_ptr;
   logic [TW-1:0]     r_tmo_cnt;
   logic              r_wb_cnt;

   logic [IDW-1:0]    w_sel;
   logic              w_found;
   logic [IDW-1:0]    w_ld_id;
   logic              w_ld;
   logic              w_ld_last;
   logic [7:0]        w_ld_data;
   logic [IDW-1:0]    w_nxt_ptr;
   logic              w_tmo_hit;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .IDW    (IDW)
   ) u_rr_pick (
      .i_req   (bus.ch_req),
      .i_ptr   (r_rr_ptr),
      .o_sel   (w_sel),
      .o_found (w_found)
   );

   // While locked only the owner is eligible; the same load path serves both cases.
   assign w_ld_id   = r_locked ? r_grant_id : w_sel;
   assign w_ld      = r_locked ? bus.ch_req[r_grant_id] : w_found;
   assign w_ld_last = bus.ch_last[w_ld_id];
   assign w_ld_data = bus.ch_data[{w_ld_id, 3'b000} +: 8];
   assign w_nxt_ptr = IDW'(next_idx(32'(w_ld_id), NUM_CH));
   assign w_tmo_hit = (r_tmo_cnt == TW'(LOCK_TIMEOUT - 1));

   always_ff @(posedge sys_clk or negedge w_n_reset) begin
      if (!w_n_reset) begin
         r_state       <= ST_IDLE;
         r_ack         <= '0;
         r_send_data   <= 8'h00;
         r_send_req    <= 1'b0;
         r_grant_valid <= 1'b0;
         r_grant_id    <= '0;
         r_locked      <= 1'b0;
         r_rr_ptr      <= '0;
         r_tmo_cnt     <= '0;
         r_wb_cnt      <= 1'b0;
      end else begin
         r_ack <= '0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_ld) begin
                  r_send_data    <= w_ld_data;
                  r_ack[w_ld_id] <= 1'b1;
                  r_grant_id     <= w_ld_id;
                  r_locked       <= ~w_ld_last;
                  r_grant_valid  <= 1'b1;
                  r_tmo_cnt      <= '0;
                  r_state        <= ST_SEND;
                  if (w_ld_last) r_rr_ptr <= w_nxt_ptr;
               end else if (r_locked) begin
                  if (w_tmo_hit) begin
                     r_locked      <= 1'b0;
                     r_grant_valid <= 1'b0;
                     r_rr_ptr      <= w_nxt_ptr;
                     r_tmo_cnt     <= '0;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  end
               end
            end
            // send_req rises the cycle after ack, then holds until ip_uart is not busy.
            ST_SEND: begin
               if (!r_send_req) begin
                  r_send_req <= 1'b1;
               end else if (!bus.send_busy) begin
                  r_send_req <= 1'b0;
                  r_wb_cnt   <= 1'b0;
                  r_state    <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               if (bus.send_busy || r_wb_cnt) r_state <= ST_WAIT_DONE;
               else                           r_wb_cnt <= 1'b1;
            end
            ST_WAIT_DONE: begin
               if (!bus.send_busy) begin
                  r_state       <= ST_IDLE;
                  r_grant_valid <= r_locked;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ch_ack      = r_ack;
   assign bus.send_data   = r_send_data;
   assign bus.send_req    = r_send_req;
   assign bus.grant_valid = r_grant_valid;
   assign bus.grant_id    = r_grant_id;
   assign bus.locked      = r_locked;

endmodule
